gearbox_24in_256out: RTL

GEARBOX_24IN_256OUT -- requirements
Module: gearbox_24in_256out

---
 rtl/gearbox_pkg.sv | 23 ++
 rtl/gearbox_out_reg.sv | 49 ++++
 rtl/gearbox_24in_256out.sv | 92 +++++++++
 3 files changed

// File: rtl/gearbox_pkg.sv
// Shared widths and out_data field layout for the 16-bit-word to 256-bit-line gearbox.
package gearbox_pkg;
  localparam int IN_W           = 24;
  localparam int LINE_W         = 256;
  localparam int BV_W           = 32;
  localparam int WORD_W         = 16;
  localparam int WORDS_PER_LINE = 16;
  localparam int CNT_W          = 4;
  localparam int OUT_W          = LINE_W + BV_W;

  // out_data = {line, byte_valid}
  localparam int OUT_LINE_MSB = OUT_W - 1;
  localparam int OUT_LINE_LSB = BV_W;
  localparam int OUT_BV_MSB   = BV_W - 1;
  localparam int OUT_BV_LSB   = 0;

  typedef logic [OUT_W-1:0] out_word_t;

  function automatic out_word_t pack_line(input logic [LINE_W-1:0] line,
                                          input logic [BV_W-1:0] bv);
    return {line, bv};
  endfunction
endpackage

// File: rtl/gearbox_out_reg.sv
// One-entry valid/ready output register with a single pending slot behind it.
module gearbox_out_reg
  import gearbox_pkg::*;
(
  input  logic      clock,
  input  logic      rst,
  input  out_word_t line_in,
  input  logic      line_vld,
  output logic      busy,
  output out_word_t out_data,
  output logic      out_valid,
  input  logic      out_ready
);

  out_word_t pend_data;
  logic      pend_vld;
  logic      room;

  assign room = !out_valid || out_ready;
  assign busy = pend_vld;

  always_ff @(posedge clock) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      pend_vld  <= 1'b0;
    end else if (room) begin
      if (pend_vld) begin
        out_data  <= pend_data;
        out_valid <= 1'b1;
        pend_vld  <= line_vld;
      end else if (line_vld) begin
        out_data  <= line_in;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (line_vld) begin
      pend_vld <= 1'b1;
    end
  end

  // Pending slot only captures when the line cannot go straight to the output.
  always_ff @(posedge clock) begin
    if ((room && pend_vld && line_vld) || (!room && line_vld))
      pend_data <= line_in;
  end

endmodule

// File: rtl/gearbox_24in_256out.sv
// Packs 16-bit words into 256-bit lines with byte-valid mask.
// Optional GB_IDLE_FLUSH_EN flushes a partial line after IDLE_TIMEOUT idle cycles.
module gearbox_24in_256out
  import gearbox_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 256
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic             flush_in,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [CNT_W-1:0]  cnt;
  logic [LINE_W-1:0] acc_line;
  logic [LINE_W-1:0] line_next;
  logic [BV_W-1:0]   acc_bv;
  logic [BV_W-1:0]   bv_next;
  logic              accept;
  logic              busy;
  logic              idle_fire;
  logic              complete;
  out_word_t         line_pkt;
  logic              unused_bits;

  assign unused_bits = ^{in_data[IN_W-1:WORD_W], IDLE_TIMEOUT[15:0]};

  assign in_ready = !rst && !busy;
  assign accept   = in_valid && in_ready;

  // Merge the accepted word into the partial line so the completing word is included.
  always_comb begin
    line_next = acc_line;
    bv_next   = acc_bv;
    if (accept) begin
      line_next[LINE_W-1-WORD_W*int'(cnt) -: WORD_W] = in_data[WORD_W-1:0];
      bv_next[BV_W-1-2*int'(cnt) -: 2]               = 2'b11;
    end
  end

  assign complete = (accept && ((cnt == CNT_W'(WORDS_PER_LINE - 1)) || in_last))
                 || (flush_in && !busy && ((cnt != '0) || accept))
                 || idle_fire;

  assign line_pkt = pack_line(line_next, bv_next);

  always_ff @(posedge clock) begin
    if (rst || complete) begin
      cnt      <= '0;
      acc_line <= '0;
      acc_bv   <= '0;
    end else if (accept) begin
      cnt      <= cnt + 1'b1;
      acc_line <= line_next;
      acc_bv   <= bv_next;
    end
  end

`ifdef GB_IDLE_FLUSH_EN
  logic [15:0] idle_cnt;

  always_ff @(posedge clock) begin
    if (rst || accept || complete || (cnt == '0))
      idle_cnt <= '0;
    else if (idle_cnt != 16'hFFFF)
      idle_cnt <= idle_cnt + 1'b1;
  end

  assign idle_fire = (cnt != '0) && !accept && !busy
                  && (idle_cnt == 16'(IDLE_TIMEOUT - 1));
`else
  assign idle_fire = 1'b0;
`endif

  gearbox_out_reg u_out_reg (
    .clock     (clock),
    .rst       (rst),
    .line_in   (line_pkt),
    .line_vld  (complete && !rst),
    .busy      (busy),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

endmodule
